// File: rtl/gt_link_ctrl_pkg.sv
// Shared types and width helpers for the GT channel link controller.
package gt_link_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WAIT_PLL   = 3'd1,
      ST_RESET      = 3'd2,
      ST_WAIT_DONE  = 3'd3,
      ST_WAIT_ALIGN = 3'd4,
      ST_LINK_UP    = 3'd5,
      ST_FAIL       = 3'd6
   } state_t;

   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int timer_width(input int rst_cycles, input int done_timeout);
      return cnt_width((rst_cycles > done_timeout) ? rst_cycles : done_timeout);
   endfunction

endpackage

// File: rtl/gt_sync_bit.sv
// Two-flop synchronizer for a single asynchronous level into the system clock domain.
module gt_sync_bit (
   input  logic clk_sys,
   input  logic rst_b,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/gt_link_ctrl.sv
// Bring-up / recovery sequencer for one 8B/10B GT channel.
// state      | meaning
// IDLE       | link not requested, GT held in reset
// WAIT_PLL   | waiting for QPLL lock, GT held in reset
// RESET      | GT resets pulsed for RST_CYCLES
// WAIT_DONE  | waiting for TX and RX reset-done
// WAIT_ALIGN | waiting for ALIGN_STABLE consecutive aligned cycles
// LINK_UP    | link usable
// FAIL       | retries exhausted, left only by dropping enable
module gt_link_ctrl
   import gt_link_ctrl_pkg::*;
#(
   parameter int RST_CYCLES   = 16,
   parameter int DONE_TIMEOUT = 65536,
   parameter int ALIGN_STABLE = 1024,
   parameter int MAX_RETRY    = 7
) (
   input  logic       i_sysclk,
   input  logic       i_rst_n,
   input  logic       i_enable,
   input  logic       i_qplllock,
   input  logic       i_tx_done,
   input  logic       i_rx_done,
   input  logic       i_rx_byte_align,
   output logic       o_tx_rst,
   output logic       o_rx_rst,
   output logic       o_link_up,
   output logic       o_link_fail,
   output logic [3:0] o_retry_cnt,
   output logic [2:0] o_state
);

   localparam int TW = timer_width(RST_CYCLES, DONE_TIMEOUT);
   localparam int SW = cnt_width(ALIGN_STABLE);
   localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
   localparam logic [TW-1:0] DONE_LAST   = TW'(DONE_TIMEOUT - 1);
   localparam logic [SW-1:0] STABLE_LAST = SW'(ALIGN_STABLE - 1);
   localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

   logic qplllock_s, tx_done_s, rx_done_s, rx_byte_align_s;

   gt_sync_bit u_sync_pll   (.clk_sys(i_sysclk), .rst_b(i_rst_n), .d(i_qplllock),      .q(qplllock_s));
   gt_sync_bit u_sync_txd   (.clk_sys(i_sysclk), .rst_b(i_rst_n), .d(i_tx_done),       .q(tx_done_s));
   gt_sync_bit u_sync_rxd   (.clk_sys(i_sysclk), .rst_b(i_rst_n), .d(i_rx_done),       .q(rx_done_s));
   gt_sync_bit u_sync_align (.clk_sys(i_sysclk), .rst_b(i_rst_n), .d(i_rx_byte_align), .q(rx_byte_align_s));

   state_t          state, state_nxt;
   logic [TW-1:0]   tmr;
   logic [SW-1:0]   stable_cnt;
   logic [3:0]      retry_cnt, retry_nxt;
   logic            retry_req;
   logic            done_s;
   logic            pll_lost;
   logic            rst_on;

   assign done_s   = tx_done_s & rx_done_s;
   assign pll_lost = !qplllock_s &&
                     (state inside {ST_RESET, ST_WAIT_DONE, ST_WAIT_ALIGN, ST_LINK_UP});

   always_comb begin
      state_nxt = state;
      retry_nxt = retry_cnt;
      retry_req = 1'b0;
      case (state)
         ST_IDLE:       state_nxt = ST_WAIT_PLL;
         ST_WAIT_PLL:   if (qplllock_s) state_nxt = ST_RESET;
         ST_RESET:      if (tmr == RST_LAST) state_nxt = ST_WAIT_DONE;
         ST_WAIT_DONE: begin
            if (done_s)                 state_nxt = ST_WAIT_ALIGN;
            else if (tmr == DONE_LAST)  retry_req = 1'b1;
         end
         ST_WAIT_ALIGN: begin
            // link-up beats a timeout landing on the same cycle
            if (rx_byte_align_s && stable_cnt == STABLE_LAST) state_nxt = ST_LINK_UP;
            else if (!done_s || tmr == DONE_LAST)             retry_req = 1'b1;
         end
         ST_LINK_UP:    if (!(rx_byte_align_s && done_s)) retry_req = 1'b1;
         ST_FAIL:       state_nxt = ST_FAIL;
         default:       state_nxt = ST_IDLE;
      endcase

      if (retry_req) begin
         if (retry_cnt == RETRY_MAX) begin
            state_nxt = ST_FAIL;
         end else begin
            state_nxt = ST_WAIT_PLL;
            retry_nxt = retry_cnt + 4'd1;
         end
      end
      if (state_nxt == ST_LINK_UP && state != ST_LINK_UP) retry_nxt = 4'd0;

      if (pll_lost) begin
         state_nxt = ST_WAIT_PLL;
         retry_nxt = retry_cnt;
      end
      if (!i_enable) begin
         state_nxt = ST_IDLE;
         retry_nxt = 4'd0;
      end

      rst_on = state_nxt inside {ST_IDLE, ST_WAIT_PLL, ST_RESET, ST_FAIL};
   end

   always_ff @(posedge i_sysclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= ST_IDLE;
         tmr         <= '0;
         stable_cnt  <= '0;
         retry_cnt   <= 4'd0;
         o_tx_rst    <= 1'b1;
         o_rx_rst    <= 1'b1;
         o_link_up   <= 1'b0;
         o_link_fail <= 1'b0;
      end else begin
         state     <= state_nxt;
         retry_cnt <= retry_nxt;
         if (state_nxt != state)  tmr <= '0;
         else if (tmr != '1)      tmr <= tmr + TW'(1);
         if (state == ST_WAIT_ALIGN && state_nxt == ST_WAIT_ALIGN && rx_byte_align_s)
            stable_cnt <= stable_cnt + SW'(1);
         else
            stable_cnt <= '0;
         o_tx_rst    <= rst_on;
         o_rx_rst    <= rst_on;
         o_link_up   <= (state_nxt == ST_LINK_UP);
         o_link_fail <= (state_nxt == ST_FAIL);
      end
   end

   assign o_state     = state;
   assign o_retry_cnt = retry_cnt;

endmodule

// File: tb/tb_gt_link_ctrl.sv
// Self-checking bench for gt_link_ctrl with short timing parameters.
module tb_gt_link_ctrl;

   localparam int RST_CYCLES   = 4;
   localparam int DONE_TIMEOUT = 100;
   localparam int ALIGN_STABLE = 8;
   localparam int MAX_RETRY    = 2;

   localparam logic [10:0] M_ALL = 11'h7FF;
   localparam logic [10:0] M_ST  = 11'h700;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0, qpll = 1'b0, txd = 1'b0, rxd = 1'b0, al = 1'b0;
   logic       o_tx_rst, o_rx_rst, o_link_up, o_link_fail;
   logic [3:0] o_retry_cnt;
   logic [2:0] o_state;

   always #5 clk = ~clk;

   gt_link_ctrl #(
      .RST_CYCLES(RST_CYCLES), .DONE_TIMEOUT(DONE_TIMEOUT),
      .ALIGN_STABLE(ALIGN_STABLE), .MAX_RETRY(MAX_RETRY)
   ) dut (
      .i_sysclk(clk), .i_rst_n(rst_n), .i_enable(en), .i_qplllock(qpll),
      .i_tx_done(txd), .i_rx_done(rxd), .i_rx_byte_align(al),
      .o_tx_rst(o_tx_rst), .o_rx_rst(o_rx_rst), .o_link_up(o_link_up),
      .o_link_fail(o_link_fail), .o_retry_cnt(o_retry_cnt), .o_state(o_state)
   );

   int total = 0;
   int bad = 0;
   logic [10:0] exp_q[$];
   logic [10:0] mask_q[$];
   string       name_q[$];

   typedef struct {
      logic en, q, txd, rxd, al;
      int n;
      logic [10:0] exp;
   } vec_t;
   vec_t vt[11];

   function automatic logic [10:0] pk(input logic [2:0] st, input logic rst,
                                      input logic lu, input logic fl, input logic [3:0] rc);
      return {st, rst, rst, lu, fl, rc};
   endfunction

   function automatic logic [10:0] obs();
      return {o_state, o_tx_rst, o_rx_rst, o_link_up, o_link_fail, o_retry_cnt};
   endfunction

   function automatic vec_t mk(input logic e, input logic q, input logic t, input logic r,
                               input logic a, input int n, input logic [10:0] x);
      vec_t v;
      v.en = e; v.q = q; v.txd = t; v.rxd = r; v.al = a; v.n = n; v.exp = x;
      return v;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic e, input logic q, input logic t, input logic r, input logic a);
      en = e; qpll = q; txd = t; rxd = r; al = a;
   endtask

   task automatic expect_out(input string nm, input logic [10:0] e, input logic [10:0] m);
      name_q.push_back(nm);
      exp_q.push_back(e);
      mask_q.push_back(m);
   endtask

   task automatic check_out();
      string nm;
      logic [10:0] e, m, o;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL scoreboard_empty: got nothing queued, required an expectation");
      end else begin
         nm = name_q.pop_front();
         e  = exp_q.pop_front();
         m  = mask_q.pop_front();
         o  = obs();
         if ((o & m) !== (e & m)) begin
            bad++;
            $display("FAIL %s: got st=%0d rst=%b%b up=%b fail=%b cnt=%0d, required st=%0d rst=%b%b up=%b fail=%b cnt=%0d (mask %h)",
                     nm, o[10:8], o[7], o[6], o[5], o[4], o[3:0],
                     e[10:8], e[7], e[6], e[5], e[4], e[3:0], m);
         end
      end
   endtask

   task automatic chk(input string nm, input logic [10:0] e, input logic [10:0] m);
      expect_out(nm, e, m);
      check_out();
   endtask

   task automatic chk_int(input string nm, input int got, input int req);
      total++;
      if (got != req) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d", nm, got, req);
      end
   endtask

   task automatic wait_state(input string nm, input logic [2:0] st, input int budget);
      int n;
      n = 0;
      while (o_state != st && n < budget) begin
         step(1);
         n++;
      end
      chk(nm, pk(st, 1'b0, 1'b0, 1'b0, 4'd0), M_ST);
   endtask

   task automatic wd_length(input string nm);
      int n;
      n = 0;
      while (o_state == 3'd3 && n < 300) begin
         n++;
         step(1);
      end
      chk_int(nm, n, DONE_TIMEOUT);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(2);
      rst_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, required test completion");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      chk("reset_vals", pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0), M_ALL);

      // nominal bring-up, timeline counted from the enable edge
      vt[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0));
      vt[1]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, pk(3'd1, 1'b1, 1'b0, 1'b0, 4'd0));
      vt[2]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, pk(3'd1, 1'b1, 1'b0, 1'b0, 4'd0));
      vt[3]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, pk(3'd2, 1'b1, 1'b0, 1'b0, 4'd0));
      vt[4]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3, pk(3'd2, 1'b1, 1'b0, 1'b0, 4'd0));
      vt[5]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, pk(3'd3, 1'b0, 1'b0, 1'b0, 4'd0));
      vt[6]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9, pk(3'd3, 1'b0, 1'b0, 1'b0, 4'd0));
      vt[7]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2, pk(3'd3, 1'b0, 1'b0, 1'b0, 4'd0));
      vt[8]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1, pk(3'd4, 1'b0, 1'b0, 1'b0, 4'd0));
      vt[9]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 7, pk(3'd4, 1'b0, 1'b0, 1'b0, 4'd0));
      vt[10] = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1, pk(3'd5, 1'b0, 1'b1, 1'b0, 4'd0));

      do_reset();
      for (int i = 0; i < 11; i++) begin
         drive(vt[i].en, vt[i].q, vt[i].txd, vt[i].rxd, vt[i].al);
         expect_out($sformatf("nominal_v%0d", i), vt[i].exp, M_ALL);
         step(vt[i].n);
         check_out();
      end

      // done timeout: tx_done never arrives
      do_reset();
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      wait_state("to_enter_wd1", 3'd3, 50);
      wd_length("to_wd_len1");
      chk("to_retry1", pk(3'd1, 1'b1, 1'b0, 1'b0, 4'd1), M_ALL);
      wait_state("to_enter_wd2", 3'd3, 50);
      wd_length("to_wd_len2");
      chk("to_retry2", pk(3'd1, 1'b1, 1'b0, 1'b0, 4'd2), M_ALL);
      wait_state("to_enter_fail", 3'd6, 200);
      chk("to_fail_out", pk(3'd6, 1'b1, 1'b0, 1'b1, 4'd2), M_ALL);
      step(5);
      chk("to_fail_sticky", pk(3'd6, 1'b1, 1'b0, 1'b1, 4'd2), M_ALL);
      en = 1'b0;
      step(1);
      chk("to_disable", pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0), M_ALL);

      // alignment glitch: 7 aligned, 1 dropped, then 8 more required
      do_reset();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      wait_state("ga_enter", 3'd4, 50);
      al = 1'b1;
      step(7);
      al = 1'b0;
      step(1);
      al = 1'b1;
      step(2);
      chk("ga_no_early", pk(3'd4, 1'b0, 1'b0, 1'b0, 4'd0), M_ALL);
      step(7);
      chk("ga_last_wait", pk(3'd4, 1'b0, 1'b0, 1'b0, 4'd0), M_ALL);
      step(1);
      chk("ga_linkup", pk(3'd5, 1'b0, 1'b1, 1'b0, 4'd0), M_ALL);

      // align_s first seen at timer 92: stable hits 8 on the timeout cycle
      do_reset();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      wait_state("tb_enter", 3'd4, 50);
      step(90);
      al = 1'b1;
      step(9);
      chk("tb_before", pk(3'd4, 1'b0, 1'b0, 1'b0, 4'd0), M_ALL);
      step(1);
      chk("tb_linkup_wins", pk(3'd5, 1'b0, 1'b1, 1'b0, 4'd0), M_ALL);

      // one cycle later is too late: timeout takes the retry path
      do_reset();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      wait_state("tl_enter", 3'd4, 50);
      step(91);
      al = 1'b1;
      step(9);
      chk("tl_timeout_retry", pk(3'd1, 1'b1, 1'b0, 1'b0, 4'd1), M_ALL);
      wait_state("tl_relink_st", 3'd5, 100);
      chk("tl_relink", pk(3'd5, 1'b0, 1'b1, 1'b0, 4'd0), M_ALL);

      // PLL loss in LINK_UP
      qpll = 1'b0;
      step(2);
      chk("pll_still_up", pk(3'd5, 1'b0, 1'b1, 1'b0, 4'd0), M_ALL);
      step(1);
      chk("pll_lost", pk(3'd1, 1'b1, 1'b0, 1'b0, 4'd0), M_ALL);
      step(5);
      chk("pll_hold", pk(3'd1, 1'b1, 1'b0, 1'b0, 4'd0), M_ALL);
      qpll = 1'b1;
      wait_state("pll_relock_st", 3'd5, 100);
      chk("pll_relock", pk(3'd5, 1'b0, 1'b1, 1'b0, 4'd0), M_ALL);

      // link drop twice
      al = 1'b0;
      step(3);
      chk("drop1", pk(3'd1, 1'b1, 1'b0, 1'b0, 4'd1), M_ALL);
      al = 1'b1;
      wait_state("drop1_relink_st", 3'd5, 100);
      chk("drop1_relink", pk(3'd5, 1'b0, 1'b1, 1'b0, 4'd0), M_ALL);
      al = 1'b0;
      step(3);
      chk("drop2", pk(3'd1, 1'b1, 1'b0, 1'b0, 4'd1), M_ALL);
      al = 1'b1;
      wait_state("drop2_relink_st", 3'd5, 100);
      chk("drop2_relink", pk(3'd5, 1'b0, 1'b1, 1'b0, 4'd0), M_ALL);

      // async reset while in WAIT_ALIGN with a nonzero retry count
      al = 1'b0;
      step(3);
      chk("ar_drop", pk(3'd1, 1'b1, 1'b0, 1'b0, 4'd1), M_ALL);
      wait_state("ar_enter_st", 3'd4, 50);
      chk("ar_in_align", pk(3'd4, 1'b0, 1'b0, 1'b0, 4'd1), M_ALL);
      #2 rst_n = 1'b0;
      #1 chk("ar_immediate", pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0), M_ALL);
      @(negedge clk);
      chk("ar_held", pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0), M_ALL);
      rst_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gt_link_ctrl.md
# gt_link_ctrl

- Sequences bring-up and recovery of one 8B/10B GT channel.
- Holds TX/RX resets while disabled or while the QPLL is unlocked.
- Pulses reset, then waits for reset-done and a stable byte alignment before declaring the link up.
- On failure it retries up to a bounded count, then latches a fail state.
- Sits between system control and the GT channel wrapper; all logic runs on the free-running system clock.

## Interface
- RST_CYCLES, 16: cycles the reset outputs are held high in RESET (≥1).
- DONE_TIMEOUT, 65536: max cycles in WAIT_DONE, and separately in WAIT_ALIGN, before a retry (≥2).
- ALIGN_STABLE, 1024: consecutive cycles of byte alignment required for link-up (≥1).
- MAX_RETRY, 7: consecutive failed attempts tolerated before FAIL (0..15).
- i_sysclk  in  1  system clock; only clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_enable  in  1  link requested; synchronous to i_sysclk.
- i_qplllock  in  1  QPLL lock; asynchronous, synchronized internally.
- i_tx_done  in  1  TX reset-FSM done; asynchronous, synchronized internally.
- i_rx_done  in  1  RX reset done; asynchronous, synchronized internally.
- i_rx_byte_align  in  1  RX byte-aligned; asynchronous, synchronized internally.
- o_tx_rst  out  1  GT TX reset, active high.
- o_rx_rst  out  1  GT RX reset, active high.
- o_link_up  out  1  link usable.
- o_link_fail  out  1  retries exhausted.
- o_retry_cnt  out  4  consecutive failed attempts.
- o_state  out  3  current state encoding, for debug.

## Operation
- The four asynchronous inputs pass through 2-flop synchronizers; the FSM sees only the synchronized copies (suffix _s).
- State encoding: IDLE=0, WAIT_PLL=1, RESET=2, WAIT_DONE=3, WAIT_ALIGN=4, LINK_UP=5, FAIL=6.
- Priority 1: if i_enable=0 in any state, next state is IDLE and o_retry_cnt clears.
- Priority 2: if qplllock_s=0 in RESET, WAIT_DONE, WAIT_ALIGN or LINK_UP, next state is WAIT_PLL. The retry count is not incremented.
- IDLE: go to WAIT_PLL when i_enable=1.
- WAIT_PLL: go to RESET when qplllock_s=1.
- RESET: the timer counts; after RST_CYCLES cycles in the state, go to WAIT_DONE.
- WAIT_DONE: go to WAIT_ALIGN when tx_done_s and rx_done_s are both 1. After DONE_TIMEOUT cycles in the state, take the retry path.
- WAIT_ALIGN: a stable counter increments while rx_byte_align_s=1 and clears to 0 when it is 0.
  - Stable counter reaches ALIGN_STABLE → go to LINK_UP.
  - Either done_s drops, or DONE_TIMEOUT cycles elapse → retry path.
  - If link-up and timeout occur in the same cycle, LINK_UP wins.
- LINK_UP: entry clears o_retry_cnt. Loss of rx_byte_align_s, rx_done_s or tx_done_s → retry path.
- Retry path:
  - If o_retry_cnt == MAX_RETRY, go to FAIL.
  - Otherwise increment o_retry_cnt and go to WAIT_PLL.
- FAIL: exits only via i_enable=0.
- Output decode:
  - o_tx_rst = o_rx_rst = 1 in IDLE, WAIT_PLL, RESET and FAIL; 0 otherwise.
  - o_link_up = 1 only in LINK_UP.
  - o_link_fail = 1 only in FAIL.
- The timer is one shared counter, cleared on every state entry. Its width is clog2(max(RST_CYCLES, DONE_TIMEOUT)+1). It saturates and never wraps.

## Timing
- Reset values: o_tx_rst=1, o_rx_rst=1, o_link_up=0, o_link_fail=0, o_retry_cnt=0, o_state=0.
- All outputs are registered and decoded from next-state, so they change in the same cycle as o_state.
- Input latency: a change on an asynchronous input acts on the FSM 2 cycles after its first sampling edge; add 1 cycle to the output.
- RESET: o_tx_rst/o_rx_rst stay high for exactly RST_CYCLES cycles after the WAIT_PLL→RESET transition, plus the IDLE/WAIT_PLL cycles before it.
- Link-up: o_link_up rises ALIGN_STABLE cycles after the first cycle in WAIT_ALIGN that sees rx_byte_align_s=1 and is not followed by a drop.
- Asynchronous reset mid-operation: state and outputs return immediately to their reset values. Synchronizer flops reset to 0.

## Structure
- gt_link_ctrl_pkg holds the state enumeration and the timer/stable-counter width helper functions.
- One sub-module, gt_sync_bit: a 2-flop synchronizer with asynchronous active-low reset, instantiated 4 times.

## Test plan
All scenarios use RST_CYCLES=4, DONE_TIMEOUT=100, ALIGN_STABLE=8, MAX_RETRY=2.

- Nominal bring-up:
  - Stimulus: i_enable=1, qplllock=1; tx/rx_done rise 10 cycles after the resets fall; align held high.
  - Required: resets high for exactly 4 cycles in RESET; o_link_up rises 8 cycles after align_s=1; o_retry_cnt=0.
- Done timeout:
  - Stimulus: tx_done never asserts.
  - Required: WAIT_DONE lasts 100 cycles; o_retry_cnt goes 1, then 2; then FAIL with o_link_fail=1 and both resets high.
  - Follow-up: i_enable=0 → IDLE, count 0.
- Alignment glitch:
  - Stimulus: align high 7 cycles, low 1 cycle, then high.
  - Required: no link-up until 8 further consecutive cycles.
  - Stimulus: align high on cycle 92 of WAIT_ALIGN, i.e. reaching 8 on the timeout cycle.
  - Required: LINK_UP is entered.
- PLL loss:
  - Stimulus: drop qplllock while in LINK_UP.
  - Required: WAIT_PLL, resets high, o_retry_cnt unchanged; relock → full re-sequence to LINK_UP.
- Link drop recovery:
  - Stimulus: drop align while in LINK_UP, twice.
  - Required: o_retry_cnt=1 on the first drop and cleared on re-link; no FAIL.
- Reset mid-operation:
  - Stimulus: assert i_rst_n low during WAIT_ALIGN.
  - Required: all outputs take their reset values immediately, asynchronously.
